// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: builds the 6-byte command frame,
// polls for the R1 response with a bounded retry count, and sends one
// trailing 0xFF with the chip select released. Talks to the byte-level SPI
// engine through the execute/busy/finished handshake.
module sd_cmd_sequencer #(
    parameter int POLL_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        ready,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout,
    output logic        cs_n,
    output logic        spi_execute,
    output logic [7:0]  spi_out_word,
    input  logic [7:0]  spi_in_word,
    input  logic        spi_busy,
    input  logic        spi_finished
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_POLL  = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    logic [1:0]  state;
    logic        issue;      // 1: ISSUE substate, 0: WAIT substate
    logic [2:0]  byte_idx;
    logic [7:0]  poll_cnt;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic [6:0]  crc7;
    logic [7:0]  next_frame_byte;

    // Bit-serial CRC7 (x^7+x^3+1) unrolled over the 40 header bits, MSB first.
    function automatic logic [6:0] crc7_calc(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // CRC depends only on latched fields, so it settles well before B5.
    always_comb begin
        crc7 = crc7_calc({2'b01, idx_q, arg_q});
    end

    // Frame byte that follows the one currently in flight.
    always_comb begin
        next_frame_byte = 8'hFF;
        case (byte_idx)
            3'd0:    next_frame_byte = arg_q[31:24];
            3'd1:    next_frame_byte = arg_q[23:16];
            3'd2:    next_frame_byte = arg_q[15:8];
            3'd3:    next_frame_byte = arg_q[7:0];
            3'd4:    next_frame_byte = {crc7, 1'b1};
            default: next_frame_byte = 8'hFF;
        endcase
    end

    assign ready = (state == S_IDLE) && !spi_busy;

    // Transaction FSM with the per-byte ISSUE/WAIT handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            issue        <= 1'b0;
            byte_idx     <= '0;
            poll_cnt     <= '0;
            idx_q        <= '0;
            arg_q        <= '0;
            cs_n         <= 1'b1;
            spi_execute  <= 1'b0;
            spi_out_word <= 8'hFF;
            done         <= 1'b0;
            r1           <= 8'hFF;
            timeout      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start && ready) begin
                    idx_q        <= cmd_index;
                    arg_q        <= cmd_arg;
                    r1           <= 8'hFF;
                    timeout      <= 1'b0;
                    cs_n         <= 1'b0;
                    state        <= S_SEND;
                    byte_idx     <= '0;
                    issue        <= 1'b1;
                    spi_execute  <= 1'b1;
                    spi_out_word <= {2'b01, cmd_index};
                end
            end else if (issue) begin
                // Engine has taken the byte once busy is observed.
                if (spi_busy) begin
                    spi_execute <= 1'b0;
                    issue       <= 1'b0;
                end
            end else if (spi_finished) begin
                // Every non-final path launches another byte.
                issue        <= 1'b1;
                spi_execute  <= 1'b1;
                spi_out_word <= 8'hFF;
                case (state)
                    S_SEND: begin
                        if (byte_idx == 3'd5) begin
                            state    <= S_POLL;
                            poll_cnt <= '0;
                        end else begin
                            byte_idx     <= byte_idx + 3'd1;
                            spi_out_word <= next_frame_byte;
                        end
                    end
                    S_POLL: begin
                        if (!spi_in_word[7]) begin
                            r1    <= spi_in_word;
                            cs_n  <= 1'b1;
                            state <= S_TRAIL;
                        end else if ({1'b0, poll_cnt} + 9'd1 == 9'(POLL_LIMIT)) begin
                            r1      <= 8'hFF;
                            timeout <= 1'b1;
                            cs_n    <= 1'b1;
                            state   <= S_TRAIL;
                        end else begin
                            poll_cnt <= poll_cnt + 8'd1;
                        end
                    end
                    default: begin
                        // Trailer byte done: transaction complete.
                        issue       <= 1'b0;
                        spi_execute <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Issues one SD-card SPI-mode command frame and collects its R1 response by driving the byte-level SPI engine through its execute/busy/finished handshake. The block sits directly upstream of the SPI byte engine and below the card initialisation and block-read control logic. It builds the 6-byte frame (start bits, index, argument, CRC7) and owns the card chip select. It polls for R1 with a bounded retry count and reports the result or a timeout.

## Interface
- POLL_LIMIT, 8, max number of 0xFF poll bytes sent while waiting for R1 (1..255)

- clk  input  1  system clock, same clock that drives the SPI byte engine; all block state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a posedge where ready=1
- cmd_index  input  6  command number, latched on accept
- cmd_arg  input  32  command argument, latched on accept
- ready  output  1  idle and spi_busy low
- done  output  1  one-cycle pulse when the transaction completes
- r1  output  8  last R1 byte, held until the next accept
- timeout  output  1  valid with done; held until the next accept
- cs_n  output  1  card chip select, active low
- spi_execute  output  1  byte-start request to the SPI engine
- spi_out_word  output  8  byte to transmit
- spi_in_word  input  8  byte received by the SPI engine
- spi_busy  input  1  SPI engine mid-byte
- spi_finished  input  1  SPI engine byte-complete pulse

## Operation
- Reset values: cs_n=1, spi_execute=0, spi_out_word=0xFF, done=0, r1=0xFF, timeout=0, state IDLE. ready=1 once spi_busy is low.
- Frame bytes, MSB first:
  - B0 = {2'b01, cmd_index}
  - B1..B4 = cmd_arg[31:24], [23:16], [15:8], [7:0]
  - B5 = {crc7, 1'b1}
- CRC7: polynomial x^7+x^3+1, init 0, computed over the 40 bits of B0..B4 MSB first. It is computed from the latched fields (serial or parallel) and must be final before B5 is issued.
- States:
  - IDLE: on start and ready, latch fields, clear r1 to 0xFF, clear timeout, cs_n<=0, go SEND with byte index 0.
  - SEND: transmit B0..B5; after B5 completes, go POLL with poll count 0.
  - POLL: transmit 0xFF.
    - On completion, if spi_in_word[7]==0: r1<=spi_in_word, go TRAIL.
    - Otherwise increment the count. When count reaches POLL_LIMIT: r1<=0xFF, timeout<=1, go TRAIL.
  - TRAIL: cs_n<=1 on entry, then transmit one 0xFF byte with cs_n high. On completion, pulse done and go IDLE.
- Byte handshake (substates ISSUE/WAIT), used by every transmitted byte:
  - ISSUE: spi_execute=1 with spi_out_word stable. Hold until a posedge sees spi_busy=1, then spi_execute<=0 and go to WAIT.
  - WAIT: on the posedge where spi_finished=1, capture spi_in_word and advance.
- cs_n is low continuously from accept through the last POLL byte.
- start while not ready is ignored, with no queuing.
- start held high across done starts a new transaction on the first cycle ready is high again.
- Reset mid-operation: all outputs return to reset values immediately (async). An in-flight SPI byte completes on its own and is discarded. ready stays low until spi_busy falls.

## Timing
- Accept to first spi_execute high: 1 cycle (cs_n falls on the same edge).
- spi_execute is high for exactly 1 cycle per byte against the SPI engine, which samples execute on negedge and raises busy at that negedge.
- Per byte: 1 cycle ISSUE + FRAME engine cycles + finished detection. spi_finished is seen on exactly one posedge.
- Total bytes per transaction: 6 + n_poll + 1, where 1 ≤ n_poll ≤ POLL_LIMIT.
- done is asserted the cycle after TRAIL's finished is seen. ready rises in the same cycle.
- r1 and timeout are stable from the done cycle until the next accept.

## Test plan
- CMD0, arg 0x00000000; card model answers 0xFF then 0x01 → MOSI 40 00 00 00 00 95 FF FF, then trailer FF with cs_n high; r1=0x01, timeout=0, a single done pulse.
- CMD8, arg 0x000001AA; card answers 0x01 on the first poll → frame 48 00 00 01 AA 87 followed by 1 poll byte; r1=0x01.
- CMD55 arg 0 → B5=0x65. CMD41 arg 0x40000000 → B5=0x77. Card answers 0x00 on the third poll → r1=0x00, exactly 3 poll bytes.
- Card always 0xFF with POLL_LIMIT=8 → exactly 8 poll bytes, r1=0xFF, timeout=1, then trailer and done.
- start pulsed during SEND is ignored (frame unchanged). start held high through done → second transaction begins once ready=1, with no missed byte.
- rst_n low during B3 → cs_n=1 and spi_execute=0 asynchronously. ready stays low until spi_busy falls; a following CMD0 completes normally.
